bcd_counter_7seg_mux: RTL and testbench

Parametrised multi-digit BCD up/down counter with an internal prescaler and a time-multiplexed, active-low 7-segment display driver. Generalises the single-digit toggle counter: N decades, up/down mode, synchronous clear/load, wrap flag and digit scanning. Sits between the board's system clock (Sys_Clk0 from the cell macro) and the display pins in the board top level.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/bcd_counter_7seg_mux_if.sv | 26 ++
 rtl/bcd_decade.sv | 45 ++++
 rtl/bcd_counter_7seg_mux.sv | 93 +++++++++
 tb/tb_bcd_counter_7seg_mux.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared BCD digit type and active-low 7-segment decode for the counter/display block.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // {a,b,c,d,e,f,g} patterns, entry 0 is the rightmost element
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] seg7_decode(input bcd_digit_t d);
        if (d <= 4'd9) begin
            return SEG_TABLE[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/bcd_counter_7seg_mux_if.sv
// Control inputs and display/count outputs of the multi-digit BCD counter.
interface bcd_counter_7seg_mux_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up_dn;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  tick;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count_bcd, tick, wrap, seg, an
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count_bcd, tick, wrap, seg, an
    );

endinterface

// File: rtl/bcd_decade.sv
// One BCD decade with ripple carry/borrow out; chained by the counter top.
module bcd_decade
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_i,
    input  logic       up_dn_i,
    input  logic       cin_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  bcd_digit_t load_digit_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = (load_digit_i > 4'd9) ? 4'd0 : load_digit_i;
        end else if (step_i && cin_i) begin
            if (up_dn_i) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign cout_o  = cin_i & (up_dn_i ? (digit_q == 4'd9) : (digit_q == 4'd0));

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// N-decade BCD up/down counter with tick prescaler and multiplexed active-low 7-segment scan.
module bcd_counter_7seg_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 20_000_000,
    parameter int REFRESH_DIV = 12_000
) (
    input logic                   clk,
    input logic                   rst_n,
    bcd_counter_7seg_mux_if.slave bus
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              wrap_q, wrap_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic                          tick_w;
    logic                          step_w;
    logic [DIGITS:0]               carry_w;
    bcd_digit_t [DIGITS-1:0]       digits_w;

    // tick gated by rst_n so it reads 0 for the whole reset cycle
    assign tick_w     = rst_n & (pre_q == PRE_W'(TICK_DIV - 1));
    assign step_w     = tick_w & bus.en;
    assign carry_w[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_decade
        bcd_decade u_decade (
            .clk          (clk),
            .rst_n        (rst_n),
            .step_i       (step_w),
            .up_dn_i      (bus.up_dn),
            .cin_i        (carry_w[i]),
            .clr_i        (bus.clr),
            .load_i       (bus.load),
            .load_digit_i (bus.load_val[4*i +: 4]),
            .digit_o      (digits_w[i]),
            .cout_o       (carry_w[i+1])
        );
    end

    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        if (bus.clr || bus.load || (pre_q == PRE_W'(TICK_DIV - 1))) begin
            pre_d = '0;
        end

        wrap_d = step_w & ~bus.clr & ~bus.load & carry_w[DIGITS];

        ref_d  = ref_q + REF_W'(1);
        scan_d = scan_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d  = '0;
            scan_d = (scan_q == SCAN_W'(DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
        end

        seg_d = seg7_decode(digits_w[scan_q]);
        an_d  = ~(DIGITS'(1) << scan_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            ref_q  <= '0;
            scan_q <= '0;
            wrap_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            pre_q  <= pre_d;
            ref_q  <= ref_d;
            scan_q <= scan_d;
            wrap_q <= wrap_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bus.count_bcd = digits_w;
    assign bus.tick      = tick_w;
    assign bus.wrap      = wrap_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Directed bench for bcd_counter_7seg_mux with DIGITS=2, TICK_DIV=4, REFRESH_DIV=3.
module tb_bcd_counter_7seg_mux;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_mism = 0;

    bcd_counter_7seg_mux_if #(.DIGITS(2)) bus ();

    bcd_counter_7seg_mux #(
        .DIGITS      (2),
        .TICK_DIV    (4),
        .REFRESH_DIV (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;

        // reset state
        edges(3);
        check("rst_count", bus.count_bcd, 8'h00);
        check("rst_seg",   bus.seg,       7'b1111111);
        check("rst_an",    bus.an,        2'b11);
        check("rst_tick",  bus.tick,      1'b0);
        check("rst_wrap",  bus.wrap,      1'b0);

        // release with en=0: first display slot then digit 1 three cycles later
        rst_n = 1'b1;
        edges(1);
        check("rel_an",    bus.an,        2'b10);
        check("rel_seg",   bus.seg,       7'b0000001);
        check("rel_count", bus.count_bcd, 8'h00);
        edges(2);
        check("rel_an_hold", bus.an,   2'b10);
        check("rel_tick",    bus.tick, 1'b1);
        edges(1);
        check("rel_an_next", bus.an,        2'b01);
        check("rel_seg_d1",  bus.seg,       7'b0000001);
        check("rel_noen",    bus.count_bcd, 8'h00);

        // count up from 98 through the all-9s wrap
        bus.en = 1'b1; bus.up_dn = 1'b1; bus.load = 1'b1; bus.load_val = 8'h98;
        edges(1);
        check("up_load", bus.count_bcd, 8'h98);
        bus.load = 1'b0;
        edges(3);
        check("up_tick1", bus.tick,      1'b1);
        check("up_pre",   bus.count_bcd, 8'h98);
        edges(1);
        check("up_99",      bus.count_bcd, 8'h99);
        check("up_99_wrap", bus.wrap,      1'b0);
        edges(3);
        check("up_99_hold", bus.count_bcd, 8'h99);
        check("up_99_nowr", bus.wrap,      1'b0);
        edges(1);
        check("up_00",      bus.count_bcd, 8'h00);
        check("up_00_wrap", bus.wrap,      1'b1);
        edges(1);
        check("up_wrap_pulse", bus.wrap,      1'b0);
        check("up_00_hold",    bus.count_bcd, 8'h00);

        // count down from 00 through the zero wrap
        bus.up_dn = 1'b0;
        edges(3);
        check("dn_99",      bus.count_bcd, 8'h99);
        check("dn_99_wrap", bus.wrap,      1'b1);
        edges(1);
        check("dn_wrap_pulse", bus.wrap, 1'b0);
        edges(3);
        check("dn_98",      bus.count_bcd, 8'h98);
        check("dn_98_wrap", bus.wrap,      1'b0);

        // invalid digit load, then clr coincident with tick
        bus.load = 1'b1; bus.load_val = 8'hA7;
        edges(1);
        check("ld_invalid", bus.count_bcd, 8'h07);
        bus.load = 1'b0; bus.up_dn = 1'b1;
        edges(3);
        check("clr_tick", bus.tick, 1'b1);
        bus.clr = 1'b1;
        edges(1);
        check("clr_count", bus.count_bcd, 8'h00);
        check("clr_wrap",  bus.wrap,      1'b0);
        bus.clr = 1'b0;
        edges(2);
        check("clr_notick", bus.tick, 1'b0);
        edges(1);
        check("clr_tick_next", bus.tick,      1'b1);
        check("clr_hold",      bus.count_bcd, 8'h00);
        edges(1);
        check("clr_step", bus.count_bcd, 8'h01);

        // reset mid-count at 45 coincident with a tick
        bus.load = 1'b1; bus.load_val = 8'h45;
        edges(1);
        check("mid_load", bus.count_bcd, 8'h45);
        bus.load = 1'b0;
        edges(3);
        check("mid_tick", bus.tick, 1'b1);
        rst_n = 1'b0;
        edges(1);
        check("mid_count", bus.count_bcd, 8'h00);
        check("mid_an",    bus.an,        2'b11);
        check("mid_seg",   bus.seg,       7'b1111111);
        check("mid_wrap",  bus.wrap,      1'b0);
        check("mid_tickr", bus.tick,      1'b0);

        // scan of 31: digit 0 shows 1, digit 1 shows 3, 3-cycle slots
        rst_n = 1'b1; bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h31;
        edges(1);
        check("scan_load", bus.count_bcd, 8'h31);
        check("scan_an0",  bus.an,        2'b10);
        check("scan_seg0", bus.seg,       7'b0000001);
        bus.load = 1'b0;
        edges(1);
        check("scan_an_d0a",  bus.an,  2'b10);
        check("scan_seg_d0a", bus.seg, 7'b1001111);
        edges(1);
        check("scan_an_d0b",  bus.an,  2'b10);
        check("scan_seg_d0b", bus.seg, 7'b1001111);
        edges(1);
        check("scan_an_d1a",  bus.an,  2'b01);
        check("scan_seg_d1a", bus.seg, 7'b0000110);
        edges(2);
        check("scan_an_d1c",  bus.an,  2'b01);
        check("scan_seg_d1c", bus.seg, 7'b0000110);
        edges(1);
        check("scan_an_back",  bus.an,  2'b10);
        check("scan_seg_back", bus.seg, 7'b1001111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
